// File: rtl/mips_pkg.sv
// Shared MIPS-style core definitions: opcode map, instruction fields, fetch states.
// FETCH_ILLEGAL_TRAP_EN adds the HALT state used by the illegal-opcode trap.
package mips_pkg;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_OR  = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h6;
  localparam logic [3:0] OP_SLT = 4'h7;
  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'hA;
  localparam logic [3:0] OP_BNE = 4'hE;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RS_MSB  = 11;
  localparam int RS_LSB  = 9;
  localparam int RT_MSB  = 8;
  localparam int RT_LSB  = 6;
  localparam int IMM_MSB = 5;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = IMM_MSB - IMM_LSB + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
`ifdef FETCH_ILLEGAL_TRAP_EN
    ,
    ST_HALT  = 2'd3
`endif
  } fetch_state_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_LW, OP_SW, OP_BNE: op_is_legal = 1'b1;
      default:                                                    op_is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC: pc + 1, plus the sign-extended imm6 when the branch is taken.
// No state and no latency; wraps modulo 2^AW.
module fetch_next_pc
  import mips_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic [AW-1:0]    pc,
  input  logic [IMM_W-1:0] imm6,
  input  logic             taken,
  output logic [AW-1:0]    next_pc
);

  logic [AW-1:0] offset;

  always_comb begin
    offset  = taken ? {{(AW-IMM_W){imm6[IMM_W-1]}}, imm6} : '0;
    next_pc = pc + AW'(1) + offset;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch/sequencing: 2 cycles per instruction at zero wait; memory waits and stalls each add a cycle.
// FETCH_ILLEGAL_TRAP_EN adds the sticky illegal flag and the HALT state.
module fetch_unit
  import mips_pkg::*;
#(
  parameter int AW       = 8,
  parameter int IW       = 16,
  parameter int RESET_PC = 0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  input  logic          stall,
  input  logic          branch,
  input  logic          PC_src,
  input  logic          zero,
  output logic [IW-1:0] instr,
  output logic [5:0]    opcode,
  output logic          instr_valid,
  output logic [AW-1:0] pc
`ifdef FETCH_ILLEGAL_TRAP_EN
  ,
  output logic          illegal
`endif
);

  fetch_state_t  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d, next_pc;
  logic [IW-1:0] instr_q, instr_d;
  logic          taken;
`ifdef FETCH_ILLEGAL_TRAP_EN
  logic          illegal_q, illegal_d;
`endif

  // BNE is taken when control selects the branch target and the operands differ.
  assign taken = branch & PC_src & ~zero;

  fetch_next_pc #(
    .AW(AW)
  ) u_next_pc (
    .pc      (pc_q),
    .imm6    (instr_q[IMM_MSB:IMM_LSB]),
    .taken   (taken),
    .next_pc (next_pc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
`ifdef FETCH_ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
`ifdef FETCH_ILLEGAL_TRAP_EN
          if (!op_is_legal(imem_rdata[OP_MSB:OP_LSB])) begin
            illegal_d = 1'b1;
            state_d   = ST_HALT;
          end else begin
            state_d   = ST_HOLD;
          end
`else
          state_d = ST_HOLD;
`endif
        end
      end
      ST_HOLD: begin
        if (!stall) begin
          pc_d    = next_pc;
          state_d = ST_FETCH;
        end
      end
`ifdef FETCH_ILLEGAL_TRAP_EN
      ST_HALT: state_d = ST_HALT;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= AW'(RESET_PC);
      instr_q   <= '0;
`ifdef FETCH_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
`ifdef FETCH_ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  assign imem_req    = (state_q == ST_FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == ST_HOLD);
  assign instr       = instr_q;
  assign opcode      = {2'b00, instr_q[OP_MSB:OP_LSB]};
  assign pc          = pc_q;
`ifdef FETCH_ILLEGAL_TRAP_EN
  assign illegal     = illegal_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam int AW       = 8;
  localparam int IW       = 16;
  localparam int RESET_PC = 0;
`ifdef FETCH_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [IW-1:0] imem_rdata;
  logic          stall, branch, PC_src, zero;
  logic [IW-1:0] instr;
  logic [5:0]    opcode;
  logic          instr_valid;
  logic [AW-1:0] pc;
`ifdef FETCH_ILLEGAL_TRAP_EN
  logic          illegal;
`endif

  fetch_unit #(.AW(AW), .IW(IW), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .branch      (branch),
    .PC_src      (PC_src),
    .zero        (zero),
    .instr       (instr),
    .opcode      (opcode),
    .instr_valid (instr_valid),
    .pc          (pc)
`ifdef FETCH_ILLEGAL_TRAP_EN
    ,
    .illegal     (illegal)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [IW-1:0] mem [256];
  int legal_ops [8] = '{0, 1, 2, 6, 7, 8, 10, 14};

  // Reference model: instruction-level view of the fetch stage.
  bit            m_idle, m_valid, m_halt, m_illegal;
  int            m_pc;
  logic [IW-1:0] m_instr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit legal_op(input int op);
    return op inside {0, 1, 2, 6, 7, 8, 10, 14};
  endfunction

  function automatic bit fetching();
    return !m_idle && !m_valid && !m_halt;
  endfunction

  task automatic model_reset();
    m_idle    = 1'b1;
    m_valid   = 1'b0;
    m_halt    = 1'b0;
    m_illegal = 1'b0;
    m_pc      = RESET_PC;
    m_instr   = '0;
  endtask

  task automatic model_step();
    int off;
    off = 0;
    if (m_idle) begin
      m_idle = 1'b0;
    end else if (m_halt) begin
      m_halt = 1'b1;
    end else if (!m_valid) begin
      if (imem_ack) begin
        m_instr = mem[m_pc];
        if (TRAP_EN && !legal_op(int'(m_instr[15:12]))) begin
          m_halt    = 1'b1;
          m_illegal = 1'b1;
        end else begin
          m_valid = 1'b1;
        end
      end
    end else if (!stall) begin
      if (branch && PC_src && !zero) off = int'($signed(m_instr[5:0]));
      m_pc    = (((m_pc + 1 + off) % 256) + 256) % 256;
      m_valid = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("imem_req", 32'(imem_req), 32'(fetching()));
    chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    chk("pc", 32'(pc), 32'(m_pc));
    chk("instr_valid", 32'(instr_valid), 32'(m_valid));
    if (m_valid) begin
      chk("instr", 32'(instr), 32'(m_instr));
      chk("opcode", 32'(opcode), 32'(m_instr[15:12]));
    end
`ifdef FETCH_ILLEGAL_TRAP_EN
    chk("illegal", 32'(illegal), 32'(m_illegal));
`endif
  endtask

  task automatic drive(input bit a, input bit s, input bit b, input bit p, input bit z);
    imem_ack   = a;
    stall      = s;
    branch     = b;
    PC_src     = p;
    zero       = z;
    imem_rdata = a ? mem[imem_addr] : IW'($urandom);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    chk("rst_req", 32'(imem_req), 32'(0));
    chk("rst_valid", 32'(instr_valid), 32'(0));
    chk("rst_pc", 32'(pc), 32'(RESET_PC));
    chk("rst_instr", 32'(instr), 32'(0));
    chk("rst_opcode", 32'(opcode), 32'(0));
`ifdef FETCH_ILLEGAL_TRAP_EN
    chk("rst_illegal", 32'(illegal), 32'(0));
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_held", 32'(imem_req), 32'(0));
    rst = 1'b0;
    model_reset();
  endtask

  task automatic run_to_pc(input int target);
    int budget;
    budget = 1200;
    while (!(fetching() && m_pc == target) && budget > 0) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
      budget--;
    end
    chk("run_to_pc", 32'(pc), 32'(target));
  endtask

  function automatic logic [IW-1:0] rand_word();
    logic [IW-1:0] w;
    w = IW'($urandom);
    if (TRAP_EN) w[15:12] = 4'(legal_ops[$urandom_range(0, 7)]);
    return w;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = rand_word();
    mem[0]     = 16'h2000;
    mem[1]     = 16'h1000;
    mem[8'h10] = 16'hE03C;
    imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0;
    branch = 1'b0; PC_src = 1'b0; zero = 1'b0;
    apply_reset();

    // Zero-wait fetch of two words.
    drive(1, 0, 0, 0, 0); cycle();
    chk("t1_addr0", 32'(imem_addr), 32'h00);
    chk("t1_req0", 32'(imem_req), 32'(1));
    drive(1, 0, 0, 0, 0); cycle();
    chk("t1_valid0", 32'(instr_valid), 32'(1));
    chk("t1_op0", 32'(opcode), 32'h02);
    drive(1, 0, 0, 0, 0); cycle();
    chk("t1_addr1", 32'(imem_addr), 32'h01);
    chk("t1_valid_low", 32'(instr_valid), 32'(0));
    drive(1, 0, 0, 0, 0); cycle();
    chk("t1_op1", 32'(opcode), 32'h01);

    // Three memory wait cycles at pc 0x05.
    run_to_pc(5);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0); cycle();
      chk("t2_req_wait", 32'(imem_req), 32'(1));
      chk("t2_valid_wait", 32'(instr_valid), 32'(0));
      chk("t2_pc_wait", 32'(pc), 32'h05);
    end
    drive(1, 0, 0, 0, 0); cycle();
    chk("t2_valid_on_ack", 32'(instr_valid), 32'(1));
    chk("t2_pc_ack", 32'(pc), 32'h05);

    // Five stall cycles in HOLD; branch inputs are don't-care meanwhile.
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 1'($urandom), 1'($urandom), 1'($urandom)); cycle();
      chk("t3_hold_valid", 32'(instr_valid), 32'(1));
      chk("t3_hold_instr", 32'(instr), 32'(mem[5]));
      chk("t3_hold_pc", 32'(pc), 32'h05);
    end
    drive(0, 0, 0, 0, 0); cycle();
    chk("t3_retire", 32'(instr_valid), 32'(0));
    chk("t3_next_pc", 32'(imem_addr), 32'h06);

    // BNE imm6=-4 at 0x10, taken then not taken.
    run_to_pc(16);
    drive(1, 0, 0, 0, 0); cycle();
    drive(0, 0, 1, 1, 0); cycle();
    chk("t4_bne_taken", 32'(imem_addr), 32'h0D);
    run_to_pc(16);
    drive(1, 0, 0, 0, 0); cycle();
    drive(0, 0, 1, 1, 1); cycle();
    chk("t4_bne_not_taken", 32'(imem_addr), 32'h11);

    // PC wrap from 0xFF.
    run_to_pc(255);
    drive(1, 0, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 0); cycle();
    chk("t5_wrap", 32'(imem_addr), 32'h00);

    // Reset asserted mid-FETCH, then restart from RESET_PC.
    #2;
    apply_reset();
    drive(1, 0, 0, 0, 0); cycle();
    chk("t6_restart_req", 32'(imem_req), 32'(1));
    chk("t6_restart_addr", 32'(imem_addr), 32'(RESET_PC));

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 256; i++) mem[i] = rand_word();
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
            1'($urandom), 1'($urandom), 1'($urandom));
      cycle();
      if ($urandom_range(0, 199) == 0) begin
        #2;
        apply_reset();
      end
    end

`ifdef FETCH_ILLEGAL_TRAP_EN
    // Illegal opcode at 0x04 halts with pc frozen until reset.
    mem[4] = 16'h3000;
    #2;
    apply_reset();
    run_to_pc(4);
    drive(1, 0, 0, 0, 0); cycle();
    chk("t7_illegal", 32'(illegal), 32'(1));
    chk("t7_req", 32'(imem_req), 32'(0));
    chk("t7_valid", 32'(instr_valid), 32'(0));
    chk("t7_pc", 32'(pc), 32'h04);
    for (int i = 0; i < 4; i++) begin
      drive(1'($urandom), 0, 0, 0, 0); cycle();
      chk("t7_halt_req", 32'(imem_req), 32'(0));
      chk("t7_halt_pc", 32'(pc), 32'h04);
    end
    #2;
    apply_reset();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
